fetch_sequencer: RTL

Sequences instruction fetch for the 32-bit MIPS core: owns the program counter, drives the byte address into the combinational big-endian instruction memory, and buffers fetched words in a 2-entry queue toward decode with a valid/ready handshake. Handles branch/jump redirects, decode stalls, end-of-memory halt and, optionally, misaligned-target traps. Sits between the instruction memory and the decode stage, replacing the free-running PC increment.

---
 rtl/mips_fetch_pkg.sv | 18 +
 rtl/fetch_queue.sv | 78 +++++++
 rtl/fetch_sequencer.sv | 111 +++++++++++
 3 files changed

// File: rtl/mips_fetch_pkg.sv
// Shared definitions for the instruction fetch sequencer: FSM state encoding,
// queue depth and the queue entry layout.
package mips_fetch_pkg;

    typedef enum logic [1:0] {
        StRun  = 2'd0,
        StHalt = 2'd1,
        StTrap = 2'd2
    } fetch_state_e;

    localparam int unsigned FETCH_Q_DEPTH = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry in-order queue between fetch and decode. Slot 0 is always the
// head; it keeps its last contents when the queue drains or is flushed, so
// the head outputs hold their previous values while empty.
module fetch_queue
    import mips_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,
    input  logic        push_i,
    input  logic [31:0] push_pc_i,
    input  logic [31:0] push_inst_i,
    input  logic        pop_i,
    output logic [31:0] head_pc_o,
    output logic [31:0] head_inst_o,
    output logic        full_o,
    output logic        empty_o
);

    fetch_entry_t slot_q [FETCH_Q_DEPTH];
    fetch_entry_t slot_d [FETCH_Q_DEPTH];
    logic [1:0]   count_q, count_d;
    fetch_entry_t entry;
    logic         do_push, do_pop;

    assign entry   = '{pc: push_pc_i, inst: push_inst_i};
    assign empty_o = (count_q == 2'd0);
    assign full_o  = (count_q == 2'(FETCH_Q_DEPTH));
    // Guard against a pop on empty or a push into a full queue without a pop.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    // Next-state for slots and occupancy count.
    always_comb begin
        slot_d  = slot_q;
        count_d = count_q;
        if (flush_i) begin
            count_d = 2'd0;
        end else begin
            case ({do_push, do_pop})
                2'b10: begin
                    if (count_q == 2'd0) slot_d[0] = entry;
                    else                 slot_d[1] = entry;
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    if (count_q == 2'd2) slot_d[0] = slot_q[1];
                    count_d = count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd2) begin
                        slot_d[0] = slot_q[1];
                        slot_d[1] = entry;
                    end else begin
                        slot_d[0] = entry;
                    end
                end
                default: ;
            endcase
        end
    end

    // Slot and count registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q[0] <= '0;
            slot_q[1] <= '0;
            count_q   <= 2'd0;
        end else begin
            slot_q  <= slot_d;
            count_q <= count_d;
        end
    end

    assign head_pc_o   = slot_q[0].pc;
    assign head_inst_o = slot_q[0].inst;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, addresses the combinational
// instruction memory and feeds a 2-entry queue toward decode.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (misaligned redirect traps).
module fetch_sequencer
    import mips_fetch_pkg::*;
#(
    parameter int unsigned ADDR_W   = 7,
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        jmp,
    input  logic [31:0] jmp_target,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        halted,
    output logic        trap
);

    // Low address bits of the final word in instruction memory.
    localparam logic [ADDR_W-1:0] LastWord = {{(ADDR_W - 2){1'b1}}, 2'b00};

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  target;
    logic         redirect;
    logic         push, pop, flush;
    logic         q_full, q_empty;

    assign redirect = jmp | br_taken;
    assign pop      = ~q_empty & inst_ready;

    // Redirect target selection; jump wins over branch.
    always_comb begin
        target = jmp ? jmp_target : br_target;
`ifndef FETCH_MISALIGN_TRAP_EN
        target[1:0] = 2'b00;
`endif
    end

    // State and PC register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StRun;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Next state, next PC and queue control.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        push    = 1'b0;
        flush   = 1'b0;
        case (state_q)
            StRun, StHalt: begin
                if (redirect) begin
                    // Redirect overrides stall and never pushes in its cycle.
                    flush   = 1'b1;
                    pc_d    = target;
                    state_d = StRun;
`ifdef FETCH_MISALIGN_TRAP_EN
                    if (target[1:0] != 2'b00) state_d = StTrap;
`endif
                end else if (state_q == StRun && !stall && (!q_full || pop)) begin
                    push = 1'b1;
                    if (pc_q[ADDR_W-1:0] == LastWord) state_d = StHalt;
                    else                              pc_d    = pc_q + 32'd4;
                end
            end
            default: ;  // TRAP: only reset leaves
        endcase
    end

    // Status outputs.
    always_comb begin
        imem_addr  = pc_q;
        inst_valid = ~q_empty;
        halted     = (state_q == StHalt);
`ifdef FETCH_MISALIGN_TRAP_EN
        trap       = (state_q == StTrap);
`else
        trap       = 1'b0;
`endif
    end

    fetch_queue u_queue (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush),
        .push_i      (push),
        .push_pc_i   (pc_q),
        .push_inst_i (imem_data),
        .pop_i       (pop),
        .head_pc_o   (inst_pc),
        .head_inst_o (inst),
        .full_o      (q_full),
        .empty_o     (q_empty)
    );

endmodule
